// File: rtl/local_mem_result_arbiter_if.sv
`default_nettype none
// ============================================================================
// local_mem_result_arbiter_if: producer/consumer side of the result mailbox.
// Rev 1.0
// ============================================================================
interface local_mem_result_arbiter_if #(
    parameter int NUM_WR = 2,
    parameter int DATA_W = 32
);
    logic                     start;
    logic [NUM_WR-1:0]        wr_req;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]        wr_grant;
    logic                     rd_req;
    logic                     rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic                     result_full;
    logic                     layer_done;

    modport slave (
        input  start, wr_req, wr_data, rd_req,
        output wr_grant, rd_valid, rd_data, result_full, layer_done
    );

    modport master (
        output start, wr_req, wr_data, rd_req,
        input  wr_grant, rd_valid, rd_data, result_full, layer_done
    );
endinterface
`default_nettype wire

// File: rtl/local_mem_result_arbiter.sv
`default_nettype none
// ============================================================================
// local_mem_result_arbiter: one-deep result mailbox, round-robin writers.
// Rev 1.0
// ============================================================================
module local_mem_result_arbiter #(
    parameter int NUM_WR     = 2,
    parameter int DATA_W     = 32,
    parameter int RESULT_CNT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    local_mem_result_arbiter_if.slave     bus,
    output logic                          write_result_signal,
    output logic [DATA_W-1:0]             write_result_data,
    output logic                          read_result_signal,
    input  logic [DATA_W-1:0]             read_result_data
);
    localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int CNT_W = $clog2(RESULT_CNT + 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic               req_hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [NUM_WR-1:0]  grant_vec;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_data;
    logic [CNT_W-1:0]   read_count;
    logic               layer_done;

    // First requester strictly after the last winner, wrapping around.
    always_comb begin
        req_hit = 1'b0;
        hit_idx = rr_ptr;
        for (int k = 1; k <= NUM_WR; k++) begin
            if (!req_hit && bus.wr_req[(int'(rr_ptr) + k) % NUM_WR]) begin
                req_hit = 1'b1;
                hit_idx = IDX_W'((int'(rr_ptr) + k) % NUM_WR);
            end
        end
    end

    always_comb begin
        state_next          = state;
        grant_vec           = '0;
        write_result_signal = 1'b0;
        write_result_data   = '0;
        read_result_signal  = 1'b0;
        if (!rst) begin
            case (state)
                EMPTY: begin
                    if (req_hit) begin
                        grant_vec[hit_idx]  = 1'b1;
                        write_result_signal = 1'b1;
                        write_result_data   = bus.wr_data[int'(hit_idx)*DATA_W +: DATA_W];
                        state_next          = FULL;
                    end
                end
                FULL: begin
                    if (bus.rd_req) begin
                        read_result_signal = 1'b1;
                        state_next         = EMPTY;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            rr_ptr     <= IDX_W'(NUM_WR - 1);
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            read_count <= '0;
            layer_done <= 1'b0;
        end else begin
            state    <= state_next;
            rd_valid <= read_result_signal;
            if (write_result_signal) begin
                rr_ptr <= hit_idx;
            end
            if (read_result_signal) begin
                rd_data <= read_result_data;
            end
            // start takes precedence over a read landing in the same cycle
            if (bus.start) begin
                read_count <= '0;
                layer_done <= 1'b0;
            end else if (read_result_signal && read_count != CNT_W'(RESULT_CNT)) begin
                read_count <= read_count + 1'b1;
                if (read_count == CNT_W'(RESULT_CNT - 1)) begin
                    layer_done <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_grant    = grant_vec;
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_data     = rd_data;
    assign bus.result_full = (state == FULL);
    assign bus.layer_done  = layer_done;

endmodule
`default_nettype wire

// File: tb/tb_local_mem_result_arbiter.sv
`default_nettype none
// ============================================================================
// tb_local_mem_result_arbiter: directed bench for the result mailbox arbiter.
// Rev 1.0
// ============================================================================
module tb_local_mem_result_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        write_result_signal;
    logic [31:0] write_result_data;
    logic        read_result_signal;
    logic [31:0] read_result_data;
    logic [31:0] mem = '0;
    int          total  = 0;
    int          passed = 0;

    local_mem_result_arbiter_if #(.NUM_WR(2), .DATA_W(32)) bus ();

    local_mem_result_arbiter #(
        .NUM_WR    (2),
        .DATA_W    (32),
        .RESULT_CNT(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus.slave),
        .write_result_signal(write_result_signal),
        .write_result_data  (write_result_data),
        .read_result_signal (read_result_signal),
        .read_result_data   (read_result_data)
    );

    always #5 clk = ~clk;

    // Result register model: returns 0 unless read-enabled
    always @(posedge clk) begin
        if (write_result_signal) mem <= write_result_data;
    end
    assign read_result_data = read_result_signal ? mem : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [31:0] d, input logic do_start);
        bus.wr_req        = 2'b01;
        bus.wr_data[31:0] = d;
        tick();
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b1;
        bus.start  = do_start;
        tick();
        bus.rd_req = 1'b0;
        bus.start  = 1'b0;
        check("pair_valid", {31'b0, bus.rd_valid}, 32'h1);
        check("pair_data", bus.rd_data, d);
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.wr_req  = 2'b11;
        bus.wr_data = {32'h0000_0022, 32'h0000_0011};
        bus.rd_req  = 1'b1;

        // 1. reset with requests asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_grant", {30'b0, bus.wr_grant}, 32'h0);
            check("rst_wsig", {31'b0, write_result_signal}, 32'h0);
            check("rst_rsig", {31'b0, read_result_signal}, 32'h0);
            check("rst_full", {31'b0, bus.result_full}, 32'h0);
            check("rst_valid", {31'b0, bus.rd_valid}, 32'h0);
            check("rst_data", bus.rd_data, 32'h0);
            check("rst_done", {31'b0, bus.layer_done}, 32'h0);
        end
        rst        = 1'b0;
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b0;

        // 2. single write then read
        tick();
        bus.wr_req        = 2'b01;
        bus.wr_data[31:0] = 32'hDEAD_BEEF;
        #1;
        check("single_grant", {30'b0, bus.wr_grant}, 32'h1);
        check("single_wsig", {31'b0, write_result_signal}, 32'h1);
        check("single_wdata", write_result_data, 32'hDEAD_BEEF);
        tick();
        bus.wr_req = 2'b00;
        check("single_full", {31'b0, bus.result_full}, 32'h1);
        bus.rd_req = 1'b1;
        #1;
        check("single_rsig", {31'b0, read_result_signal}, 32'h1);
        tick();
        bus.rd_req = 1'b0;
        check("single_valid", {31'b0, bus.rd_valid}, 32'h1);
        check("single_rdata", bus.rd_data, 32'hDEAD_BEEF);
        check("single_empty", {31'b0, bus.result_full}, 32'h0);
        tick();
        check("single_pulse", {31'b0, bus.rd_valid}, 32'h0);
        check("single_hold", bus.rd_data, 32'hDEAD_BEEF);

        // 3. contention from a fresh round-robin pointer
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        bus.wr_req  = 2'b11;
        bus.wr_data = {32'h0000_0022, 32'h0000_0011};
        bus.rd_req  = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("cont_grant", {30'b0, bus.wr_grant}, (k % 2 == 1) ? 32'h2 : 32'h1);
            tick();
            check("cont_stall", {30'b0, bus.wr_grant}, 32'h0);
            check("cont_rsig", {31'b0, read_result_signal}, 32'h1);
            check("cont_novalid", {31'b0, bus.rd_valid}, 32'h0);
            tick();
            if (k == 3) begin
                bus.wr_req = 2'b00;
                bus.rd_req = 1'b0;
            end
            check("cont_valid", {31'b0, bus.rd_valid}, 32'h1);
            check("cont_rdata", bus.rd_data, (k % 2 == 1) ? 32'h22 : 32'h11);
        end

        // 4. back-pressure
        bus.wr_req        = 2'b01;
        bus.wr_data[31:0] = 32'h0000_00A5;
        #1;
        check("bp_grant0", {30'b0, bus.wr_grant}, 32'h1);
        tick();
        bus.wr_req         = 2'b10;
        bus.wr_data[63:32] = 32'h0000_005A;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_nogrant", {30'b0, bus.wr_grant}, 32'h0);
            check("bp_nowsig", {31'b0, write_result_signal}, 32'h0);
            check("bp_full", {31'b0, bus.result_full}, 32'h1);
            tick();
        end
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        check("bp_rdata", bus.rd_data, 32'h0000_00A5);
        check("bp_grant1", {30'b0, bus.wr_grant}, 32'h2);
        check("bp_wdata1", write_result_data, 32'h0000_005A);
        tick();
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        check("bp_rdata2", bus.rd_data, 32'h0000_005A);

        // 5. reads while empty are ignored
        bus.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("er_rsig", {31'b0, read_result_signal}, 32'h0);
            tick();
            check("er_valid", {31'b0, bus.rd_valid}, 32'h0);
        end
        bus.rd_req = 1'b0;

        // 6. layer counting
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ly_start", {31'b0, bus.layer_done}, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            pair(32'h100 + 32'(k), 1'b0);
            check("ly_done", {31'b0, bus.layer_done}, (k >= 4) ? 32'h1 : 32'h0);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ly_clear", {31'b0, bus.layer_done}, 32'h0);

        // reset mid-layer: count restarts and the stale entry is dropped
        pair(32'h0000_0201, 1'b0);
        bus.wr_req        = 2'b01;
        bus.wr_data[31:0] = 32'h0000_0202;
        tick();
        bus.wr_req = 2'b00;
        check("ly_full2", {31'b0, bus.result_full}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ly_rst_full", {31'b0, bus.result_full}, 32'h0);
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        check("ly_stale", {31'b0, bus.rd_valid}, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            pair(32'h300 + 32'(k), 1'b0);
            check("ly_rst_cnt", {31'b0, bus.layer_done}, (k == 4) ? 32'h1 : 32'h0);
        end

        // start coinciding with the final read wins
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 3; k++) pair(32'h400 + 32'(k), 1'b0);
        pair(32'h0000_0404, 1'b1);
        check("ly_start_wins", {31'b0, bus.layer_done}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
